// File: rtl/min_channel_arbiter_if.sv
// ---------------------------------------------------------------------------
// min_channel_arbiter_if
// Bundles the channel request side and the framer side of the arbiter.
//   i_en        capture enable (low ignores new requests)
//   i_req       per-channel one-cycle sample-ready strobes
//   i_data      packed channel payloads, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_busy      framer transmitting flag
//   o_start     one-cycle start pulse to the framer
//   o_id        frame ID of the current grant
//   o_data      frame payload of the current grant
//   o_pending   per-channel pending flags
//   o_drop_cnt  saturating count of overwritten unsent samples
// master: the side that drives requests and the framer busy flag.
// slave : the arbiter itself.
// ---------------------------------------------------------------------------
interface min_channel_arbiter_if #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 32
);
    logic                       i_en;
    logic [N_CH-1:0]            i_req;
    logic [N_CH*DATA_WIDTH-1:0] i_data;
    logic                       i_busy;
    logic                       o_start;
    logic [7:0]                 o_id;
    logic [DATA_WIDTH-1:0]      o_data;
    logic [N_CH-1:0]            o_pending;
    logic [7:0]                 o_drop_cnt;

    modport master (
        output i_en, i_req, i_data, i_busy,
        input  o_start, o_id, o_data, o_pending, o_drop_cnt
    );

    modport slave (
        input  i_en, i_req, i_data, i_busy,
        output o_start, o_id, o_data, o_pending, o_drop_cnt
    );
endinterface

// File: rtl/min_channel_arbiter.sv
// ---------------------------------------------------------------------------
// min_channel_arbiter
// Collects decimated samples from N_CH channels into per-channel capture
// registers and hands them one at a time to a MIN framer, round-robin.
// Ports:
//   i_clk  single clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    min_channel_arbiter_if.slave (requests, payloads, framer handshake,
//          pending flags and drop counter)
// ---------------------------------------------------------------------------
module min_channel_arbiter #(
    parameter int         N_CH       = 4,
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] ID_BASE    = 8'h08,
    parameter int         TIMEOUT    = 15
) (
    input logic                  i_clk,
    input logic                  i_rst,
    min_channel_arbiter_if.slave bus
);

    localparam int CW = $clog2(N_CH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         last_q, last_d;
    logic [N_CH-1:0]       pend_q, pend_d;
    logic [7:0]            drop_q, drop_d;
    logic [7:0]            id_q, id_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] cap_q [N_CH];

    logic [N_CH-1:0]       cap_en;
    logic [N_CH-1:0]       grant_clr;
    logic [N_CH-1:0]       drop_ev;
    logic                  grant_valid;
    logic [CW-1:0]         grant_idx;
    logic [8:0]            drop_sum;

    assign cap_en = bus.i_req & {N_CH{bus.i_en}};

    // Per-channel capture registers; a capture always overwrites, even when
    // the old sample is still pending.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_cap
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    cap_q[gi] <= '0;
                end else if (cap_en[gi]) begin
                    cap_q[gi] <= bus.i_data[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    endgenerate

    // Round-robin search: first pending channel starting after last grant.
    always_comb begin
        int            tmp;
        logic [CW-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        tmp         = 0;
        cand        = '0;
        for (int i = 1; i <= N_CH; i++) begin
            tmp = int'(last_q) + i;
            if (tmp >= N_CH) begin
                tmp = tmp - N_CH;
            end
            cand = CW'(tmp);
            if (!grant_valid && pend_q[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // FSM next state plus grant-time latching of the frame fields.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        data_d    = data_q;
        tmo_d     = tmo_q;
        grant_clr = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    grant_clr[grant_idx] = 1'b1;
                    last_d               = grant_idx;
                    id_d                 = ID_BASE + 8'(grant_idx);
                    data_d               = cap_q[grant_idx];
                    state_d              = S_START;
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Framer never answered: give up on this frame, no retry.
                if (bus.i_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.i_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending flags and drop counting. A capture into the channel being
    // granted this cycle is not a drop: the old value leaves with the grant.
    always_comb begin
        drop_ev  = cap_en & pend_q & ~grant_clr;
        pend_d   = (pend_q & ~grant_clr) | cap_en;
        drop_sum = {1'b0, drop_q};
        for (int i = 0; i < N_CH; i++) begin
            drop_sum = drop_sum + 9'(drop_ev[i]);
        end
        drop_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            last_q  <= CW'(N_CH - 1);
            pend_q  <= '0;
            drop_q  <= '0;
            id_q    <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            id_q    <= id_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.o_start    = (state_q == S_START);
    assign bus.o_id       = id_q;
    assign bus.o_data     = data_q;
    assign bus.o_pending  = pend_q;
    assign bus.o_drop_cnt = drop_q;

endmodule

// File: doc/min_channel_arbiter.md
MIN_CHANNEL_ARBITER -- requirements
Module: min_channel_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of requesting decimated-sample channels (2..8).
REQ-002 Parameter DATA_WIDTH, default 32, payload bits per channel sample.
REQ-003 Parameter ID_BASE, default 8'h08, MIN frame ID for channel 0; channel k uses ID_BASE+k.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles to wait for framer busy after a start pulse.
REQ-005 Port: i_clk, input, 1, single clock (sclk domain); all logic on rising edge.
REQ-006 Port: i_rst, input, 1, reset, asynchronous, active-high.
REQ-007 Port: i_en, input, 1, capture enable; low ignores new requests.
REQ-008 Port: i_req, input, N_CH, per-channel one-cycle sample-ready strobe.
REQ-009 Port: i_data, input, N_CH*DATA_WIDTH, channel k payload in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port: i_busy, input, 1, framer transmitting flag.
REQ-011 Port: o_start, output, 1, one-cycle start pulse to framer.
REQ-012 Port: o_id, output, 8, frame ID, valid from o_start until the next grant.
REQ-013 Port: o_data, output, DATA_WIDTH, frame payload, held stable under the same rule as o_id.
REQ-014 Port: o_pending, output, N_CH, per-channel pending flags.
REQ-015 Port: o_drop_cnt, output, 8, saturating count of overwritten unsent samples.

Function
REQ-016 Each channel SHALL have a capture register and pending flag; i_req[k]&&i_en SHALL load the slice into the register and set pending[k] on the next edge.
REQ-017 A capture into an already-pending channel not granted that cycle SHALL overwrite the data and increment o_drop_cnt by 1, saturating at 255.
REQ-018 The FSM SHALL have states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-019 IDLE: if any pending, grant the first pending channel searching upward from last_grant+1 modulo N_CH.
REQ-020 IDLE: the grant cycle SHALL latch that capture register into o_data and ID_BASE+k into o_id, clear pending[k], update last_grant, and enter START.
REQ-021 START SHALL assert o_start for exactly one cycle and enter WAIT_BUSY.
REQ-022 WAIT_BUSY: i_busy high enters WAIT_DONE; after TIMEOUT cycles without i_busy, return to IDLE with no retry.
REQ-023 WAIT_DONE: i_busy low returns to IDLE; the next grant is possible in that IDLE cycle.
REQ-024 Total latency from a request on an idle arbiter to o_start SHALL be 2 cycles: capture, grant, then start.
REQ-025 A request on the channel being granted in the same cycle: the grant takes the old register value, the new sample is captured, pending stays 1, no drop counted.
REQ-026 Simultaneous requests on several channels SHALL all be captured in one cycle; grants follow round-robin order.
REQ-027 i_en low SHALL block captures only; pending flags stay set and the FSM keeps granting them.
REQ-028 o_pending SHALL be registered pending flags; o_drop_cnt SHALL be a register.

Reset
REQ-029 i_rst SHALL asynchronously clear the FSM to IDLE, and clear to 0 o_start, o_id, o_data, o_pending, o_drop_cnt and all capture registers.
REQ-030 i_rst SHALL set last_grant to N_CH-1 so channel 0 has first priority.
REQ-031 Reset mid-frame SHALL abandon the frame with no o_start after release.
REQ-032 Outputs SHALL stay at reset values until the first pending grant after i_rst deasserts.

Verification
REQ-033 Single request, idle: i_req=0001, data0=32'hDEADBEEF -> o_start 2 cycles later, o_id=8'h08, o_data=32'hDEADBEEF, o_pending=0.
REQ-034 Simultaneous i_req=1111, i_busy high 3 cycles per frame -> grants 0,1,2,3 in order, IDs 08..0B, four o_start pulses.
REQ-035 Channel 2 requested 3 times while framer busy -> o_drop_cnt=2, the last sample is sent; after 300 such overwrites the count stays at 255.
REQ-036 i_busy never asserts -> return to IDLE TIMEOUT+1 cycles after o_start; the next pending channel is granted.
REQ-037 i_rst pulsed during WAIT_DONE with channels pending -> all outputs 0 immediately, no o_start after release.
REQ-038 i_en=0 with i_req pulses -> no capture, o_pending unchanged, o_drop_cnt unchanged.
